// File: rtl/vga_fb_scan_if.sv
// ---------------------------------------------------------------------------
// vga_fb_scan_if
// Framebuffer read port between the scan-out engine and a synchronous-read
// RAM (BRAM port B).
//   mem_addr  ADDR_W  read address          (scan engine -> RAM)
//   mem_en    1       read enable           (scan engine -> RAM)
//   mem_data  RGB_W   read data, returned a fixed latency after mem_en
// master: scan engine side; slave: RAM side.
// ---------------------------------------------------------------------------
interface vga_fb_scan_if #(
  parameter int ADDR_W = 19,
  parameter int RGB_W  = 12
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [RGB_W-1:0]  mem_data;

  modport master (output mem_addr, output mem_en, input  mem_data);
  modport slave  (input  mem_addr, input  mem_en, output mem_data);
endinterface

// File: rtl/vga_fb_scan.sv
// ---------------------------------------------------------------------------
// vga_fb_scan
// VGA scan-out engine: free-running H/V timing counters, framebuffer fetch
// with optional 2^SCALE_SHIFT pixel/line replication, and a delay line that
// lines hs/vs/de up with RAM read data so all video outputs change together.
// Ports:
//   clk          pixel clock
//   rstn         asynchronous active-low reset
//   en           picture enable, sampled when a frame begins
//   fb           framebuffer read port (master side)
//   hs, vs       sync outputs, active level HS_POL / VS_POL
//   de           display enable, aligned with rgb
//   rgb          pixel colour, 0 in blanking or while the picture is off
//   frame_start  1-cycle pulse while the counters sit at (0,0)
// ---------------------------------------------------------------------------
module vga_fb_scan #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 0,
  parameter int RGB_W       = 12,
  parameter int MEM_LAT     = 1,
  parameter int ADDR_W      = 19
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  vga_fb_scan_if.master    fb,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT      = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT      = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] HS_FIRST   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] VS_FIRST   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [H_W-1:0] H_MASK     = H_W'((1 << SCALE_SHIFT) - 1);
  localparam logic [V_W-1:0] V_MASK     = V_W'((1 << SCALE_SHIFT) - 1);

  // started is low for the first edge after reset: the counters hold (0,0)
  // for one more cycle so frame_start and the first fetch are registered
  // like every later frame.
  logic             started;
  logic [H_W-1:0]   h_cnt, h_nxt;
  logic [V_W-1:0]   v_cnt, v_nxt;
  logic             run, run_nxt;
  logic [ADDR_W-1:0] line_base, line_nxt;
  logic [ADDR_W-1:0] col, col_nxt;
  logic             first_nxt, fetch_nxt;

  // Next counter position and the framebuffer row base / column for it.
  // Fetch outputs are registered from these so mem_en/mem_addr line up
  // with the counters they belong to.
  always_comb begin
    h_nxt    = '0;
    v_nxt    = '0;
    line_nxt = '0;
    col_nxt  = '0;
    if (started) begin
      if (h_cnt == H_LAST) begin
        if (v_cnt != V_LAST) begin
          v_nxt    = v_cnt + V_W'(1);
          line_nxt = line_base;
          // a framebuffer row covers 2^S screen lines
          if (v_cnt < V_ACT && (v_nxt & V_MASK) == '0)
            line_nxt = line_base + ADDR_W'(FB_W);
        end
      end else begin
        h_nxt    = h_cnt + H_W'(1);
        v_nxt    = v_cnt;
        line_nxt = line_base;
        col_nxt  = col;
        if (h_cnt < H_ACT && (h_nxt & H_MASK) == '0)
          col_nxt = col + ADDR_W'(1);
      end
    end
  end

  // run is only reloaded on entry to (0,0); the same value gates the fetch
  // of pixel (0,0), so a frame is never split between two en settings.
  assign first_nxt = (h_nxt == '0) && (v_nxt == '0);
  assign run_nxt   = first_nxt ? en : run;
  assign fetch_nxt = run_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      started     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_base   <= '0;
      col         <= '0;
      run         <= 1'b0;
      frame_start <= 1'b0;
      fb.mem_en   <= 1'b0;
      fb.mem_addr <= '0;
    end else begin
      started     <= 1'b1;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      line_base   <= line_nxt;
      col         <= col_nxt;
      run         <= run_nxt;
      frame_start <= first_nxt;
      fb.mem_en   <= fetch_nxt;
      if (fetch_nxt)
        fb.mem_addr <= line_nxt + col_nxt;
    end
  end

  // Timing flags for the current counter position, active-high internally.
  logic hs_raw, vs_raw, de_raw;
  assign hs_raw = started && (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_raw = started && (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign de_raw = started && (h_cnt < H_ACT) && (v_cnt < V_ACT);

  // Delay line matching the RAM read latency: {hs, vs, de, run}
  logic [3:0] pipe [MEM_LAT];
  logic [3:0] tail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= {hs_raw, vs_raw, de_raw, run};
      for (int i = 1; i < MEM_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[MEM_LAT-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs  <= ~HS_POL;
      vs  <= ~VS_POL;
      de  <= 1'b0;
      rgb <= '0;
    end else begin
      hs  <= tail[3] ? HS_POL : ~HS_POL;
      vs  <= tail[2] ? VS_POL : ~VS_POL;
      de  <= tail[1];
      rgb <= (tail[1] && tail[0]) ? fb.mem_data : '0;
    end
  end

endmodule
